// File: rtl/pulse_gen_pkg.sv
// Shared types and encodings for the sequenced pulse generator.
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_HP0 = 2'b00;
    localparam logic [1:0] MODE_HP1 = 2'b01;
    localparam logic [1:0] MODE_HP2 = 2'b10;
    localparam logic [1:0] MODE_HYB = 2'b11;

    typedef enum logic [1:0] {
        STEP_HP0 = 2'd0,
        STEP_HP1 = 2'd1,
        STEP_HP2 = 2'd2
    } ramp_step_t;

    // HP0 -> HP1 -> HP2 -> HP0 ...
    function automatic ramp_step_t next_step(input ramp_step_t s);
        case (s)
            STEP_HP0: return STEP_HP1;
            STEP_HP1: return STEP_HP2;
            default:  return STEP_HP0;
        endcase
    endfunction

endpackage

// File: rtl/tick_div.sv
// Free-running 1 Hz divider: 50% square wave plus a one-cycle strobe on
// each rising edge of that square wave. Also used by the display block.
module tick_div #(
    parameter int SEC_DIV = 100000000
) (
    input  logic clk,
    input  logic rst,
    output logic clk_1hz,
    output logic tick_1hz
);
    localparam int            DW      = $clog2(SEC_DIV);
    localparam logic [DW-1:0] HALF_M1 = DW'(SEC_DIV / 2 - 1);

    logic [DW-1:0] cnt;

    // Count half-periods; toggle the square wave and strobe on the 0->1 side.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            clk_1hz  <= 1'b0;
            tick_1hz <= 1'b0;
        end else begin
            tick_1hz <= 1'b0;
            if (cnt == HALF_M1) begin
                cnt      <= '0;
                clk_1hz  <= ~clk_1hz;
                tick_1hz <= ~clk_1hz;
            end else begin
                cnt <= cnt + DW'(1);
            end
        end
    end

endmodule

// File: rtl/pulse_gen_seq.sv
// Sequenced square-pulse generator with preset/runtime half-periods,
// continuous or burst runs, pulse counting and a 1 Hz side output.
// Optional: PULSE_GEN_SEQ_RAMP_EN makes mode 11 step HP0->HP1->HP2 on
// every 1 Hz tick while running instead of using hp_cfg.
module pulse_gen_seq
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int HP0     = 16,
    parameter int HP1     = 32,
    parameter int HP2     = 64,
    parameter int SEC_DIV = 100000000,
    parameter int PCNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  hp_cfg,
    input  logic [PCNT_W-1:0] burst_len,
    output logic              pulse,
    output logic              busy,
    output logic              done,
    output logic [PCNT_W-1:0] pulse_cnt,
    output logic              clk_1hz,
    output logic              tick_1hz
);
    logic [1:0]        rst_sync;
    logic              rst_i;
    state_t            state;
    logic              start_q;
    logic              start_rise;
    logic [PCNT_W-1:0] blen;
    logic [CNT_W-1:0]  phase;
    logic [CNT_W-1:0]  hp;
    logic [CNT_W-1:0]  sel_raw;
    logic [CNT_W-1:0]  sel_hp;

    // Assert asynchronously, release two clocks after rst rises.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync <= 2'b00;
        else      rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_i = rst_sync[1];

    assign start_rise = start & ~start_q;

    tick_div #(.SEC_DIV(SEC_DIV)) u_tick_div (
        .clk      (clk),
        .rst      (rst_i),
        .clk_1hz  (clk_1hz),
        .tick_1hz (tick_1hz)
    );

`ifdef PULSE_GEN_SEQ_RAMP_EN
    ramp_step_t step;

    // Ramp index sits at HP0 outside RUN and advances on each 1 Hz tick in RUN.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i)             step <= STEP_HP0;
        else if (state != RUN)  step <= STEP_HP0;
        else if (tick_1hz)      step <= next_step(step);
    end
`endif

    // Candidate half-period from mode, clamped to at least one cycle.
    always_comb begin
        sel_raw = hp_cfg;
        case (mode)
            MODE_HP0: sel_raw = CNT_W'(HP0);
            MODE_HP1: sel_raw = CNT_W'(HP1);
            MODE_HP2: sel_raw = CNT_W'(HP2);
            default: begin
`ifdef PULSE_GEN_SEQ_RAMP_EN
                case (step)
                    STEP_HP0: sel_raw = CNT_W'(HP0);
                    STEP_HP1: sel_raw = CNT_W'(HP1);
                    default:  sel_raw = CNT_W'(HP2);
                endcase
`else
                sel_raw = hp_cfg;
`endif
            end
        endcase
        sel_hp = (sel_raw == '0) ? CNT_W'(1) : sel_raw;
    end

    // Run FSM; hp is only reloaded at entry and at toggles so pulse never runts.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            start_q   <= 1'b0;
            blen      <= '0;
            pulse_cnt <= '0;
            phase     <= '0;
            hp        <= CNT_W'(1);
            pulse     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            start_q <= start;
            case (state)
                IDLE: begin
                    if (start_rise) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        blen      <= burst_len;
                        pulse_cnt <= '0;
                        phase     <= '0;
                        pulse     <= 1'b0;
                        hp        <= sel_hp;
                    end
                end
                RUN: begin
                    if (!start) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        pulse <= 1'b0;
                        phase <= '0;
                    end else if (phase == hp - CNT_W'(1)) begin
                        phase <= '0;
                        pulse <= ~pulse;
                        hp    <= sel_hp;
                        if (!pulse) begin
                            if (pulse_cnt != '1) pulse_cnt <= pulse_cnt + PCNT_W'(1);
                        end else if (blen != '0 && pulse_cnt == blen) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        phase <= phase + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (!start) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    pulse <= 1'b0;
                end
            endcase
        end
    end

endmodule
